// File: rtl/bdi_pkg.sv
// Shared definitions for the base-delta-immediate line compressor: CoN tags, encoded sizes,
// scanner state encoding and the per-word fit vector.
package bdi_pkg;

  localparam logic [3:0] CON_ZERO = 4'd0;
  localparam logic [3:0] CON_B8D1 = 4'd1;
  localparam logic [3:0] CON_B8D2 = 4'd2;
  localparam logic [3:0] CON_B8D4 = 4'd3;
  localparam logic [3:0] CON_B2D1 = 4'd6;
  localparam logic [3:0] CON_REP8 = 4'd7;
  localparam logic [3:0] CON_RAW  = 4'd8;
  localparam logic [3:0] CON_REP4 = 4'd9;

  localparam logic [8:0] BITS_ZERO = 9'd4;
  localparam logic [8:0] BITS_REP4 = 9'd36;
  localparam logic [8:0] BITS_REP8 = 9'd68;
  localparam logic [8:0] BITS_B8D1 = 9'd104;
  localparam logic [8:0] BITS_B8D2 = 9'd136;
  localparam logic [8:0] BITS_B2D1 = 9'd164;
  localparam logic [8:0] BITS_B8D4 = 9'd200;
  localparam logic [8:0] BITS_RAW  = 9'd260;

  // Field offsets inside the encoded word
  localparam int unsigned OFF_FLAGS  = 4;
  localparam int unsigned OFF_BASE8  = 8;
  localparam int unsigned OFF_DELTA8 = 72;
  localparam int unsigned OFF_BASE2  = 20;
  localparam int unsigned OFF_HDELTA = 44;

  typedef enum logic [1:0] {StIdle, StScan, StPack, StDone} state_e;

  typedef struct packed {
    logic zero;
    logic rep8;
    logic rep4;
    logic d1;
    logic d2;
    logic d4;
    logic b2;
  } fit_t;

endpackage

// File: rtl/bdi_word_fit.sv
// Combinational per-word evaluation of every BDI encoding against the latched bases,
// plus the sign flags and delta magnitudes the packer needs.
module bdi_word_fit
  import bdi_pkg::*;
(
  input  logic [63:0] word,
  input  logic [63:0] base8,
  input  logic [31:0] base4,
  input  logic [15:0] base2,
  output fit_t        fit,
  output logic        flag,
  output logic [31:0] delta,
  output logic [3:0]  hflag,
  output logic [31:0] hdelta
);

  logic [63:0] diff;
  logic [15:0] hd [4];

  always_comb begin
    flag     = (word >= base8);
    diff     = flag ? word - base8 : base8 - word;
    delta    = diff[31:0];
    fit.zero = (word == 64'd0);
    fit.rep8 = (word == base8);
    fit.rep4 = (word[31:0] == base4) && (word[63:32] == base4);
    fit.d1   = (diff[63:8] == 56'd0);
    fit.d2   = (diff[63:16] == 48'd0);
    fit.d4   = (diff[63:32] == 32'd0);
    fit.b2   = 1'b1;
    hflag    = '0;
    hdelta   = '0;
    for (int j = 0; j < 4; j++) begin
      hflag[j]         = (word[16*j +: 16] >= base2);
      hd[j]            = hflag[j] ? word[16*j +: 16] - base2 : base2 - word[16*j +: 16];
      hdelta[8*j +: 8] = hd[j][7:0];
      if (hd[j][15:8] != 8'd0) fit.b2 = 1'b0;
    end
  end

endmodule

// File: rtl/bdi_compressor_unit.sv
// Multi-cycle BDI line compressor: scans one 64-bit word per cycle, narrows the fit set,
// then packs the smallest encoding into a held output word.
module bdi_compressor_unit
  import bdi_pkg::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ENC_W  = 276
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINE_W-1:0] line_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ENC_W-1:0]  enc_out,
  output logic [8:0]        enc_bits,
  output logic [31:0]       lines_done
);

  state_e             state_q;
  logic [1:0]         idx_q;
  logic [LINE_W-1:0]  line_q;
  fit_t               fit_q;
  logic [3:0]         wflag_q;
  logic [127:0]       wdelta_q;
  logic [14:0]        hflag_q;   // halfwords 1..15; halfword 0 is the base itself
  logic [119:0]       hdelta_q;
  logic [ENC_W-1:0]   enc_q, enc_d;
  logic [8:0]         bits_q, bits_d;
  logic               in_ready_q, out_valid_q;
  logic [31:0]        lines_done_q;

  fit_t        fit_w;
  logic        flag_w;
  logic [31:0] delta_w, hdelta_w;
  logic [3:0]  hflag_w;

  bdi_word_fit u_word_fit (
    .word   (line_q[{idx_q, 6'd0} +: 64]),
    .base8  (line_q[63:0]),
    .base4  (line_q[31:0]),
    .base2  (line_q[15:0]),
    .fit    (fit_w),
    .flag   (flag_w),
    .delta  (delta_w),
    .hflag  (hflag_w),
    .hdelta (hdelta_w)
  );

  always_comb begin
    enc_d  = '0;
    bits_d = BITS_RAW;
    if (fit_q.zero) begin
      enc_d[3:0] = CON_ZERO;
      bits_d     = BITS_ZERO;
    end else if (fit_q.rep4) begin
      enc_d[3:0]  = CON_REP4;
      enc_d[35:4] = line_q[31:0];
      bits_d      = BITS_REP4;
    end else if (fit_q.rep8) begin
      enc_d[3:0]  = CON_REP8;
      enc_d[67:4] = line_q[63:0];
      bits_d      = BITS_REP8;
    end else if (fit_q.d1 || fit_q.d2) begin
      enc_d[3:0]              = fit_q.d1 ? CON_B8D1 : CON_B8D2;
      enc_d[OFF_FLAGS +: 4]   = wflag_q;
      enc_d[OFF_BASE8 +: 64]  = line_q[63:0];
      bits_d                  = fit_q.d1 ? BITS_B8D1 : BITS_B8D2;
      for (int k = 0; k < 4; k++) begin
        if (fit_q.d1) enc_d[OFF_DELTA8 + 8*k +: 8] = wdelta_q[32*k +: 8];
        else          enc_d[OFF_DELTA8 + 16*k +: 16] = wdelta_q[32*k +: 16];
      end
    end else if (fit_q.b2) begin
      enc_d[3:0]               = CON_B2D1;
      enc_d[OFF_FLAGS +: 15]   = hflag_q;
      enc_d[OFF_BASE2 +: 16]   = line_q[15:0];
      enc_d[OFF_HDELTA +: 120] = hdelta_q;
      bits_d                   = BITS_B2D1;
    end else if (fit_q.d4) begin
      enc_d[3:0]               = CON_B8D4;
      enc_d[OFF_FLAGS +: 4]    = wflag_q;
      enc_d[OFF_BASE8 +: 64]   = line_q[63:0];
      enc_d[OFF_DELTA8 +: 128] = wdelta_q;
      bits_d                   = BITS_B8D4;
    end else begin
      enc_d[3:0]          = CON_RAW;
      enc_d[4 +: LINE_W]  = line_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      line_q       <= '0;
      fit_q        <= '0;
      wflag_q      <= '0;
      wdelta_q     <= '0;
      hflag_q      <= '0;
      hdelta_q     <= '0;
      enc_q        <= '0;
      bits_q       <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      lines_done_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            line_q     <= line_in;
            fit_q      <= '1;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StScan;
          end
        end
        StScan: begin
          // Shift registers leave word k / halfword k at its natural slot after four steps
          fit_q    <= fit_t'(fit_q & fit_w);
          wflag_q  <= {flag_w, wflag_q[3:1]};
          wdelta_q <= {delta_w, wdelta_q[127:32]};
          hflag_q  <= {hflag_w, hflag_q[14:4]};
          hdelta_q <= {hdelta_w, hdelta_q[119:32]};
          idx_q    <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= StPack;
        end
        StPack: begin
          enc_q       <= enc_d;
          bits_q      <= bits_d;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            lines_done_q <= lines_done_q + 32'd1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign enc_out    = enc_q;
  assign enc_bits   = bits_q;
  assign lines_done = lines_done_q;

endmodule

// File: tb/tb_bdi_compressor_unit.sv
// Directed-vector bench for bdi_compressor_unit with hand-computed encodings.
module tb_bdi_compressor_unit;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [255:0] line_in;
  logic [275:0] enc_out;
  logic [8:0]   enc_bits;
  logic [31:0]  lines_done;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done = 0;

  always #5 clk = ~clk;

  bdi_compressor_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .line_in    (line_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .enc_out    (enc_out),
    .enc_bits   (enc_bits),
    .lines_done (lines_done)
  );

  function automatic logic [255:0] mk(input logic [63:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // edges counts the accepting edge as 1, so first out_valid after the 5th later edge gives 6
  task automatic run_line(input logic [255:0] l, output int edges, output bit timeout);
    timeout = 1'b1;
    edges   = 0;
    @(negedge clk);
    line_in  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 edges++;
      if (out_valid) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; line_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    n_checks++;
    if (enc_out !== 276'd0 || enc_bits !== 9'd0 || lines_done !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: enc=%h bits=%0d done=%0d want 0 0 0", enc_out, enc_bits,
               lines_done);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_enc(input string name, input logic [255:0] l, input logic [275:0] exp,
                          input logic [8:0] exp_bits);
    int e;
    bit to;
    run_line(l, e, to);
    n_checks++;
    if (to || e != 6) begin
      n_fail++;
      $display("FAIL %s_latency: timeout=%0d edges=%0d want 0 6", name, to, e);
    end
    n_checks++;
    if (enc_out !== exp) begin
      n_fail++;
      $display("FAIL %s_enc: got %h want %h", name, enc_out, exp);
    end
    n_checks++;
    if (enc_bits !== exp_bits) begin
      n_fail++;
      $display("FAIL %s_bits: got %0d want %0d", name, enc_bits, exp_bits);
    end
    @(posedge clk);
    #1 exp_done++;
    n_checks++;
    if (lines_done !== 32'(exp_done) || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: lines_done=%0d out_valid=%b want %0d 0", name, lines_done,
               out_valid, exp_done);
    end
  endtask

  task automatic test_encodings;
    logic [275:0] exp;
    logic [255:0] l;
    test_enc("zero", '0, 276'h0, 9'd4);

    exp = '0; exp[3:0] = 4'd7; exp[67:4] = 64'h1122_3344_5566_7788;
    l = mk(64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788,
           64'h1122_3344_5566_7788);
    test_enc("rep8", l, exp, 9'd68);

    exp = '0; exp[3:0] = 4'd9; exp[35:4] = 32'hDEAD_BEEF;
    l = mk(64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF,
           64'hDEAD_BEEF_DEAD_BEEF);
    test_enc("rep4", l, exp, 9'd36);

    exp = '0; exp[3:0] = 4'd2; exp[7:4] = 4'b1011; exp[71:8] = 64'h5000;
    exp[135:72] = {16'h0000, 16'h0100, 16'hFFFF, 16'h0000};
    test_enc("b8d2", mk(64'h5000, 64'h14FFF, 64'h4F00, 64'h5000), exp, 9'd136);

    // Largest delta that still fits four bytes
    exp = '0; exp[3:0] = 4'd3; exp[7:4] = 4'hF; exp[71:8] = 64'h10000;
    exp[199:72] = {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    test_enc("b8d4", mk(64'h10000, 64'h1_0000_FFFF, 64'h10000, 64'h10000), exp, 9'd200);

    // Delta of exactly 2^32, and a halfword 0x100 away from base2, force raw
    l = mk(64'h10000, 64'h1_0001_0000, 64'h10100, 64'h10000);
    exp = '0; exp[3:0] = 4'd8; exp[259:4] = l;
    test_enc("raw", l, exp, 9'd260);

    exp = '0; exp[3:0] = 4'd6; exp[18:4] = 15'h7DFF; exp[35:20] = 16'h0100;
    exp[163:44] = 120'hFF00FF00FF10FF008000FF00FF00FF;
    l = mk(64'h01FF_0100_01FF_0100, 64'h0180_0100_01FF_0100, 64'h01FF_00F0_01FF_0100,
           64'h01FF_0100_01FF_0100);
    test_enc("b2d1", l, exp, 9'd164);
  endtask

  task automatic test_b8d1_decode;
    logic [275:0] exp;
    logic [255:0] l, rec;
    logic [63:0]  b;
    logic [7:0]   d;
    l = mk(64'h1000, 64'h1005, 64'h0FFD, 64'h10FF);
    exp = '0; exp[3:0] = 4'd1; exp[7:4] = 4'b1011; exp[71:8] = 64'h1000;
    exp[103:72] = 32'hFF03_0500;
    test_enc("b8d1", l, exp, 9'd104);
    b = enc_out[71:8];
    for (int k = 0; k < 4; k++) begin
      d = enc_out[72 + 8*k +: 8];
      rec[64*k +: 64] = enc_out[4 + k] ? b + 64'(d) : b - 64'(d);
    end
    n_checks++;
    if (rec !== l) begin
      n_fail++;
      $display("FAIL b8d1_decode: got %h want %h", rec, l);
    end
  endtask

  task automatic test_back_to_back;
    logic [275:0] exp_b;
    logic [255:0] lb;
    int e, gap;
    bit to;
    lb = mk(64'hCAFE_0001_CAFE_0001, 64'hCAFE_0001_CAFE_0001, 64'hCAFE_0001_CAFE_0001,
            64'hCAFE_0001_CAFE_0001);
    exp_b = '0; exp_b[3:0] = 4'd9; exp_b[35:4] = 32'hCAFE_0001;
    // Line B sits on in_valid for the whole of line A's processing and must wait
    @(negedge clk);
    line_in = '0; in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 line_in = lb;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        to = 1'b0;
        break;
      end
    end
    n_checks++;
    if (to || enc_out !== 276'h0) begin
      n_fail++;
      $display("FAIL b2b_first: timeout=%0d enc=%h want 0 0", to, enc_out);
    end
    gap = 0;
    to  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) in_valid = 1'b0;
      if (out_valid) begin
        to  = 1'b0;
        gap = i;
        break;
      end
    end
    exp_done++;
    n_checks++;
    if (to || gap != 7) begin
      n_fail++;
      $display("FAIL b2b_gap: timeout=%0d gap=%0d want 0 7", to, gap);
    end
    n_checks++;
    if (enc_out !== exp_b || enc_bits !== 9'd36) begin
      n_fail++;
      $display("FAIL b2b_second: enc=%h bits=%0d want %h 36", enc_out, enc_bits, exp_b);
    end
    @(posedge clk);
    #1 exp_done++;
    n_checks++;
    if (lines_done !== 32'(exp_done)) begin
      n_fail++;
      $display("FAIL b2b_done: lines_done=%0d want %0d", lines_done, exp_done);
    end
    e = 0;
  endtask

  task automatic test_backpressure_reset;
    logic [275:0] exp;
    int e, bad;
    bit to;
    exp = '0; exp[3:0] = 4'd7; exp[67:4] = 64'h0123_4567_89AB_CDEF;
    out_ready = 1'b0;
    run_line(mk(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF), e, to);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (enc_out !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (to || bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: timeout=%0d bad_cycles=%0d want 0 0", to, bad);
    end
    n_checks++;
    if (lines_done !== 32'(exp_done)) begin
      n_fail++;
      $display("FAIL hold_done: lines_done=%0d want %0d", lines_done, exp_done);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_done = 0;
    n_checks++;
    if (out_valid !== 1'b0 || lines_done !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid: out_valid=%b lines_done=%0d want 0 0", out_valid, lines_done);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_encodings();
    test_b8d1_decode();
    test_back_to_back();
    test_backpressure_reset();
    test_enc("post_rst", '0, 276'h0, 9'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
